// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter
//   Shares one dual-port RAM with a one-cycle registered read output between
//   NUM_REQ requesters. Every cycle a round-robin scan starting at rr_ptr
//   grants up to two requests. The first valid requester goes to port A. The
//   next valid requester that has no same-address hazard against A goes to
//   port B. Granted commands are registered onto the RAM ports. Read data
//   comes back two cycles after the grant, tagged with the requester index.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_wren           per-requester request valid / write flag
//   req_addr/req_wdata           flattened per-requester address / write data
//   req_grant                    combinational accept (transfer = valid & grant)
//   ram_address/wren/data_a|b    registered RAM command, one set per port
//   ram_out_a|b                  RAM read data
//   rd_valid/rd_tag/rd_data_a|b  tagged read return, aligned with ram_out
//   perf_busy_a|b                port busy-cycle counters
//
// Optional feature (macro DPRAM_ARB_PERF_CNT_EN)
//   Defined   : perf_busy_a/b count the cycles in which their port carries a
//               granted command. They saturate and clear on reset.
//   Undefined : perf_busy_a/b are tied to zero.

module dpram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 60
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [AWIDTH-1:0]         ram_address_a,
  output logic [AWIDTH-1:0]         ram_address_b,
  output logic                      ram_wren_a,
  output logic                      ram_wren_b,
  output logic [DWIDTH-1:0]         ram_data_a,
  output logic [DWIDTH-1:0]         ram_data_b,
  input  logic [DWIDTH-1:0]         ram_out_a,
  input  logic [DWIDTH-1:0]         ram_out_b,
  output logic                      rd_valid_a,
  output logic                      rd_valid_b,
  output logic [IDW-1:0]            rd_tag_a,
  output logic [IDW-1:0]            rd_tag_b,
  output logic [DWIDTH-1:0]         rd_data_a,
  output logic [DWIDTH-1:0]         rd_data_b,
  output logic [31:0]               perf_busy_a,
  output logic [31:0]               perf_busy_b
);

  logic [AWIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DWIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AWIDTH +: AWIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  logic [IDW-1:0] rr_ptr_reg;
  logic           grant_a_vld, grant_b_vld;
  logic [IDW-1:0] idx_a, idx_b;
  logic [IDW-1:0] last_idx, rr_ptr_next;

  // Round-robin scan. A requester that collides with A (same address and
  // either side writes) only loses port B. A later clean requester may still
  // take B.
  always_comb begin
    grant_a_vld = 1'b0;
    grant_b_vld = 1'b0;
    idx_a       = '0;
    idx_b       = '0;
    req_grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int             idx;
      logic [IDW-1:0] cand;
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (req_valid[cand]) begin
        if (!grant_a_vld) begin
          grant_a_vld = 1'b1;
          idx_a       = cand;
        end else if (!grant_b_vld &&
                     !((addr_arr[cand] == addr_arr[idx_a]) &&
                       (req_wren[cand] || req_wren[idx_a]))) begin
          grant_b_vld = 1'b1;
          idx_b       = cand;
        end
      end
    end
    if (reset) begin
      grant_a_vld = 1'b0;
      grant_b_vld = 1'b0;
    end
    if (grant_a_vld) req_grant[idx_a] = 1'b1;
    if (grant_b_vld) req_grant[idx_b] = 1'b1;
  end

  // The pointer moves just past the last requester served this cycle.
  assign last_idx    = grant_b_vld ? idx_b : idx_a;
  assign rr_ptr_next = (last_idx == IDW'(NUM_REQ - 1)) ? '0 : last_idx + IDW'(1);

  // Reads issued to the RAM this cycle. These are delayed one more stage so
  // that they line up with the RAM's registered output.
  logic           issue_rd_a_reg, issue_rd_b_reg;
  logic [IDW-1:0] issue_tag_a_reg, issue_tag_b_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg      <= '0;
      ram_address_a   <= '0;
      ram_address_b   <= '0;
      ram_wren_a      <= 1'b0;
      ram_wren_b      <= 1'b0;
      ram_data_a      <= '0;
      ram_data_b      <= '0;
      issue_rd_a_reg  <= 1'b0;
      issue_rd_b_reg  <= 1'b0;
      issue_tag_a_reg <= '0;
      issue_tag_b_reg <= '0;
      rd_valid_a      <= 1'b0;
      rd_valid_b      <= 1'b0;
      rd_tag_a        <= '0;
      rd_tag_b        <= '0;
    end else begin
      // An idle port keeps its address and data and performs a harmless read.
      ram_wren_a <= grant_a_vld & req_wren[idx_a];
      ram_wren_b <= grant_b_vld & req_wren[idx_b];
      if (grant_a_vld) begin
        ram_address_a <= addr_arr[idx_a];
        ram_data_a    <= wdata_arr[idx_a];
      end
      if (grant_b_vld) begin
        ram_address_b <= addr_arr[idx_b];
        ram_data_b    <= wdata_arr[idx_b];
      end
      issue_rd_a_reg  <= grant_a_vld & ~req_wren[idx_a];
      issue_rd_b_reg  <= grant_b_vld & ~req_wren[idx_b];
      issue_tag_a_reg <= idx_a;
      issue_tag_b_reg <= idx_b;
      rd_valid_a      <= issue_rd_a_reg;
      rd_valid_b      <= issue_rd_b_reg;
      rd_tag_a        <= issue_tag_a_reg;
      rd_tag_b        <= issue_tag_b_reg;
      if (grant_a_vld) rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign rd_data_a = ram_out_a;
  assign rd_data_b = ram_out_b;

`ifdef DPRAM_ARB_PERF_CNT_EN
  // A port counts as busy in the cycle its registered command is at the RAM.
  logic        cmd_vld_a_reg, cmd_vld_b_reg;
  logic [31:0] busy_a_reg, busy_b_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_vld_a_reg <= 1'b0;
      cmd_vld_b_reg <= 1'b0;
      busy_a_reg    <= '0;
      busy_b_reg    <= '0;
    end else begin
      cmd_vld_a_reg <= grant_a_vld;
      cmd_vld_b_reg <= grant_b_vld;
      if (cmd_vld_a_reg && (busy_a_reg != 32'hFFFF_FFFF)) busy_a_reg <= busy_a_reg + 32'd1;
      if (cmd_vld_b_reg && (busy_b_reg != 32'hFFFF_FFFF)) busy_b_reg <= busy_b_reg + 32'd1;
    end
  end

  assign perf_busy_a = busy_a_reg;
  assign perf_busy_b = busy_b_reg;
`else
  assign perf_busy_a = '0;
  assign perf_busy_b = '0;
`endif

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Randomized and directed bench for dpram_rr_arbiter.
// A reference model predicts the grants from the arbitration rules. Expected
// read returns (tag, data and due cycle) go into per-port queues, and a
// separate monitor pops and compares them whenever rd_valid is seen.
module tb_dpram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 60;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_wren, req_grant;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [AW-1:0]   ram_address_a, ram_address_b;
  logic            ram_wren_a, ram_wren_b;
  logic [DW-1:0]   ram_data_a, ram_data_b, ram_out_a, ram_out_b;
  logic            rd_valid_a, rd_valid_b;
  logic [1:0]      rd_tag_a, rd_tag_b;
  logic [DW-1:0]   rd_data_a, rd_data_b;
  logic [31:0]     perf_busy_a, perf_busy_b;

  dpram_rr_arbiter #(.NUM_REQ(N), .IDW(2), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_out_a(ram_out_a), .ram_out_b(ram_out_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .perf_busy_a(perf_busy_a), .perf_busy_b(perf_busy_b)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a registered read (read-old-data).
  logic [DW-1:0] tb_mem [4096];
  always @(posedge clk) begin
    if (ram_wren_a) tb_mem[ram_address_a] <= ram_data_a;
    if (ram_wren_b) tb_mem[ram_address_b] <= ram_data_b;
    ram_out_a <= tb_mem[ram_address_a];
    ram_out_b <= tb_mem[ram_address_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Reference state: the memory contents and the requests still waiting.
  typedef struct {int tag; logic [DW-1:0] data; int due;} exp_t;
  exp_t          q [2][$];
  logic [DW-1:0] ref_mem [4096];
  int            rr_m;
  logic          pend_v [N];
  logic          pend_w [N];
  logic [AW-1:0] pend_a [N];
  logic [DW-1:0] pend_d [N];

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend_v[i];
      req_wren[i]            = pend_w[i];
      req_addr[i*AW +: AW]   = pend_a[i];
      req_wdata[i*DW +: DW]  = pend_d[i];
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[i] = 1'b1; pend_w[i] = w; pend_a[i] = a; pend_d[i] = d;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
  endtask

  // The rotation order starts at rr_m. The first waiting requester takes A.
  // B goes to the first later requester that does not clash with A.
  task automatic model_cycle();
    int ga, gb, g, i;
    int gp [2];
    logic [N-1:0] expg;
    exp_t e;
    ga = -1; gb = -1;
    for (int k = 0; k < N; k++) begin
      i = (rr_m + k) % N;
      if (pend_v[i]) begin
        if (ga < 0) ga = i;
        else if (gb < 0 && !(pend_a[i] == pend_a[ga] && (pend_w[i] || pend_w[ga]))) gb = i;
      end
    end
    expg = '0;
    if (ga >= 0) expg[ga] = 1'b1;
    if (gb >= 0) expg[gb] = 1'b1;
    chk("req_grant", 64'(req_grant), 64'(expg));
    gp[0] = ga; gp[1] = gb;
    for (int p = 0; p < 2; p++) begin
      if (gp[p] >= 0) begin
        g = gp[p];
        if (pend_w[g]) begin
          ref_mem[pend_a[g]] = pend_d[g];
          $display("cyc %0d port %0d write req %0d addr %03h data %015h", cyc, p, g, pend_a[g], pend_d[g]);
        end else begin
          e.tag = g; e.data = ref_mem[pend_a[g]]; e.due = cyc + 2;
          q[p].push_back(e);
        end
        pend_v[g] = 1'b0;
      end
    end
    if (ga >= 0) rr_m = (((gb >= 0) ? gb : ga) + 1) % N;
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    model_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic refill_random();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i] && ($urandom % 2 == 1))
        set_req(i, ($urandom % 3 == 0), AW'($urandom_range(0, 15)), DW'({$urandom, $urandom}));
    end
  endtask

  // Reset with every requester asserting valid: no grant may appear. Reads
  // granted just before reset are dropped, so the expected queues are
  // cleared after the first reset cycle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    req_valid = '1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("grant_in_reset", 64'(req_grant), 64'd0);
      if (c >= 1) begin
        chk("rst_wren_a", 64'(ram_wren_a), 64'd0);
        chk("rst_wren_b", 64'(ram_wren_b), 64'd0);
        chk("rst_addr_a", 64'(ram_address_a), 64'd0);
        chk("rst_addr_b", 64'(ram_address_b), 64'd0);
        chk("rst_data_a", 64'(ram_data_a), 64'd0);
        chk("rst_data_b", 64'(ram_data_b), 64'd0);
        chk("rst_rdv_a", 64'(rd_valid_a), 64'd0);
        chk("rst_rdv_b", 64'(rd_valid_b), 64'd0);
        chk("rst_tag_a", 64'(rd_tag_a), 64'd0);
        chk("rst_tag_b", 64'(rd_tag_b), 64'd0);
        chk("rst_perf_a", 64'(perf_busy_a), 64'd0);
        chk("rst_perf_b", 64'(perf_busy_b), 64'd0);
      end
      if (c == 0) begin
        #1;
        q[0].delete();
        q[1].delete();
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    clear_pend();
    rr_m = 0;
    drive_inputs();
  endtask

  // Monitor: compares every returned read against the scoreboard and flags
  // reads that are late, missing or unexpected.
  initial begin : monitor
    exp_t          e;
    logic          mv;
    logic [1:0]    mt;
    logic [DW-1:0] md;
    string         pn;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        mv = (p == 0) ? rd_valid_a : rd_valid_b;
        mt = (p == 0) ? rd_tag_a : rd_tag_b;
        md = (p == 0) ? rd_data_a : rd_data_b;
        pn = (p == 0) ? "a" : "b";
        if (mv === 1'b1) begin
          if (q[p].size() == 0) begin
            chk({"rd_spurious_", pn}, 64'(mv), 64'd0);
          end else begin
            e = q[p].pop_front();
            $display("cyc %0d port %s read tag %0d data %015h", cyc, pn, mt, md);
            chk({"rd_tag_", pn}, 64'(mt), 64'(e.tag));
            chk({"rd_data_", pn}, 64'(md), 64'(e.data));
            chk({"rd_latency_", pn}, 64'(cyc), 64'(e.due));
          end
        end else if (q[p].size() != 0 && q[p][0].due <= cyc) begin
          chk({"rd_missing_", pn}, 64'(mv), 64'd1);
          void'(q[p].pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] v;
    int exp_perf;
    int any_pend;
    for (int i = 0; i < 4096; i++) begin
      v = DW'({$urandom, $urandom});
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    req_addr = '0; req_wdata = '0; req_wren = '0; req_valid = '0;
    clear_pend();
    for (int i = 0; i < N; i++) begin pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0; end
    rr_m = 0;
    do_reset(3);

    // Four simultaneous reads: 0/1 first, then 2/3.
    set_req(0, 1'b0, 12'd10, '0); set_req(1, 1'b0, 12'd20, '0);
    set_req(2, 1'b0, 12'd30, '0); set_req(3, 1'b0, 12'd40, '0);
    idle(5);

    // Write/read hazard on the same address: the read waits one cycle.
    do_reset(2);
    set_req(0, 1'b1, 12'h055, 60'h123); set_req(1, 1'b0, 12'h055, '0);
    idle(5);

    // Two requesters clash with the writer, so the clean requester 3 takes B.
    do_reset(2);
    set_req(0, 1'b1, 12'h7FF, 60'hABC); set_req(1, 1'b0, 12'h7FF, '0);
    set_req(2, 1'b0, 12'h7FF, '0);      set_req(3, 1'b0, 12'h001, '0);
    idle(6);

    // Lone requester: port A only.
    do_reset(2);
    for (int c = 0; c < 5; c++) begin
      set_req(2, 1'b0, AW'($urandom_range(0, 4095)), '0);
      step();
    end
    idle(3);

    // Reset right after a read grant drops that read.
    do_reset(2);
    set_req(0, 1'b0, 12'h100, '0);
    step();
    do_reset(3);
    idle(3);

    // Ten cycles of dual grants for the busy counters.
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      set_req(0, 1'b0, AW'($urandom_range(0, 4095)), '0);
      set_req(1, 1'b0, AW'($urandom_range(0, 4095)), '0);
      step();
    end
    idle(4);
`ifdef DPRAM_ARB_PERF_CNT_EN
    exp_perf = 10;
`else
    exp_perf = 0;
`endif
    chk("perf_busy_a", 64'(perf_busy_a), 64'(exp_perf));
    chk("perf_busy_b", 64'(perf_busy_b), 64'(exp_perf));

    // Random traffic with a small address pool so that hazards are common.
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      refill_random();
      step();
    end
    for (int c = 0; c < 50; c++) begin
      any_pend = 0;
      for (int i = 0; i < N; i++) if (pend_v[i]) any_pend = 1;
      if (any_pend == 0) break;
      step();
    end
    chk("drain_pending", 64'(any_pend), 64'd0);
    idle(4);
    chk("queue_a_empty", 64'(q[0].size()), 64'd0);
    chk("queue_b_empty", 64'(q[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
